// File: rtl/dice_pkg.sv
// Shared dice definitions: die types, side mapping, pool FSM states.
package dice_pkg;

  localparam int POOL_W = 4;

  typedef enum logic [1:0] {
    D4  = 2'b00,
    D6  = 2'b01,
    D8  = 2'b10,
    D20 = 2'b11
  } die_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PULSE   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } pool_state_t;

  // Number of faces N for a die type.
  function automatic logic [7:0] die_sides(die_t d);
    case (d)
      D4:      return 8'd4;
      D6:      return 8'd6;
      D8:      return 8'd8;
      default: return 8'd20;
    endcase
  endfunction

endpackage

// File: rtl/dice_pool_accum.sv
// Result accumulator for one pool: sum, min, max, max-face count, range error.
module dice_pool_accum #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             capture,
  input  logic [7:0]       value,
  input  logic [7:0]       sides,
  output logic [8:0]       sum,
  output logic [7:0]       min_seen,
  output logic [7:0]       max_seen,
  output logic [CNT_W-1:0] crit_count,
  output logic             range_err
);

  logic [8:0]       sum_q;
  logic [7:0]       min_q;
  logic [7:0]       max_q;
  logic [CNT_W-1:0] crit_q;
  logic             err_q;
  logic             any_q;   // at least one result captured since clear

  // Clear on an accepted request, fold in one result per capture strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      min_q  <= 8'hFF;
      max_q  <= '0;
      crit_q <= '0;
      err_q  <= 1'b0;
      any_q  <= 1'b0;
    end else if (clear) begin
      sum_q  <= '0;
      min_q  <= 8'hFF;
      max_q  <= '0;
      crit_q <= '0;
      err_q  <= 1'b0;
      any_q  <= 1'b0;
    end else if (capture) begin
      // NOTE: non-blocking assignments so every register sees the pre-edge
      // values of its neighbours, independent of statement order.
      sum_q <= sum_q + {1'b0, value};
      if (value < min_q) min_q <= value;
      if (value > max_q) max_q <= value;
      if (value == sides) crit_q <= crit_q + 1'b1;
      if (value == 8'd0 || value > sides) err_q <= 1'b1;
      any_q <= 1'b1;
    end
  end

  assign sum        = sum_q;
  // Empty pool leaves min at its 8'hFF seed; report 0 instead.
  assign min_seen   = any_q ? min_q : 8'd0;
  assign max_seen   = max_q;
  assign crit_count = crit_q;
  assign range_err  = err_q;

endmodule

// File: rtl/dice_pool_sequencer.sv
// Rolls a pool of identical dice through an external roller and reports
// sum/min/max/crit statistics with a one-cycle done pulse.
module dice_pool_sequencer
  import dice_pkg::*;
#(
  parameter int SETTLE   = 2,
  parameter int MAX_POOL = (1 << POOL_W) - 1,
  localparam int CNT_W   = $clog2(MAX_POOL + 1),
  localparam int SET_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] pool_count,
  input  logic [1:0]       pool_die,
  output logic             busy,
  output logic             done,
  output logic [8:0]       sum,
  output logic [7:0]       min_seen,
  output logic [7:0]       max_seen,
  output logic [CNT_W-1:0] crit_count,
  output logic             range_err,
  output logic [1:0]       die_select,
  output logic             roll,
  input  logic [7:0]       rolled_number
);

  pool_state_t      state, state_nxt;
  logic [CNT_W-1:0] remaining;
  logic [SET_W-1:0] settle_cnt;
  die_t             die_q;
  logic             roll_q;
  logic             accept;

  assign accept = (state == IDLE) && start;

  // Next-state decode for the pool FSM.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned,
    // which would otherwise infer a latch.
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (pool_count == '0) ? DONE : PULSE;
      PULSE:   state_nxt = WAIT;
      WAIT:    if (settle_cnt == '0) state_nxt = CAPTURE;
      CAPTURE: state_nxt = (remaining == CNT_W'(1)) ? DONE : PULSE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, request latches, settle and remaining-dice counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      remaining  <= '0;
      settle_cnt <= '0;
      die_q      <= D4;
      roll_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      // roll is registered so the roller sees a glitch-free edge.
      roll_q <= (state_nxt == PULSE);
      if (accept) begin
        remaining <= pool_count;
        die_q     <= die_t'(pool_die);
      end
      if (state == PULSE) settle_cnt <= SET_W'(SETTLE - 1);
      else if (state == WAIT && settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
      if (state == CAPTURE) remaining <= remaining - 1'b1;
    end
  end

  dice_pool_accum #(.CNT_W(CNT_W)) u_accum (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (accept),
    .capture    (state == CAPTURE),
    .value      (rolled_number),
    .sides      (die_sides(die_q)),
    .sum        (sum),
    .min_seen   (min_seen),
    .max_seen   (max_seen),
    .crit_count (crit_count),
    .range_err  (range_err)
  );

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign roll       = roll_q;
  assign die_select = die_q;

endmodule
